// File: rtl/ddp_hs_pkg.sv
// Handshake state types and source tags shared by the branch, merge and join
// stages of the Send/Ack datapath.
package ddp_hs_pkg;

  typedef enum logic [1:0] {
    I_IDLE  = 2'd0,
    I_ACK_A = 2'd1,
    I_ACK_B = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_SEND = 2'd1,
    O_REL  = 2'd2
  } out_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Source tag of a one-hot two-way grant.
  function automatic logic gnt_src(input logic [1:0] gnt);
    return gnt[1] ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the input that wins the
// next contended grant and only moves when a contended grant is taken.
module rr_arb2
  import ddp_hs_pkg::*;
(
  input  logic       CLK,
  input  logic       MR,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_ptr == SRC_B) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      rr_ptr <= SRC_A;
    end else if (grant_en && (&req)) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/cm_merge.sv
// Two-way merge of return-to-zero Send/Ack channels through a one-entry
// buffer; contention resolved round-robin, each packet tagged with its source.
//
// state    | meaning
// I_IDLE   | waiting for a request while the buffer is empty
// I_ACK_A  | packet from a captured, Ack_out_a held until Send_in_a drops
// I_ACK_B  | packet from b captured, Ack_out_b held until Send_in_b drops
// O_IDLE   | nothing offered downstream
// O_SEND   | Send_out high, waiting for Ack_in
// O_REL    | buffer released, waiting for Ack_in to return to zero
module cm_merge
  import ddp_hs_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         MR,
  input  logic         Send_in_a,
  input  logic [W-1:0] Data_in_a,
  output logic         Ack_out_a,
  input  logic         Send_in_b,
  input  logic [W-1:0] Data_in_b,
  output logic         Ack_out_b,
  output logic         Send_out,
  output logic [W-1:0] Data_out,
  output logic         Src_out,
  input  logic         Ack_in,
  output logic         CP
);

  in_state_t  in_state;
  out_state_t out_state;
  logic       full;
  logic       grant_en;
  logic [1:0] gnt;

  assign grant_en = (in_state == I_IDLE) && !full;

  rr_arb2 u_arb (
    .CLK      (CLK),
    .MR       (MR),
    .req      ({Send_in_b, Send_in_a}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  // Capture needs full=0 and release needs full=1, so the two writes to full
  // below can never land on the same edge.
  always_ff @(posedge CLK) begin
    if (MR) begin
      in_state  <= I_IDLE;
      out_state <= O_IDLE;
      full      <= 1'b0;
      Ack_out_a <= 1'b0;
      Ack_out_b <= 1'b0;
      Send_out  <= 1'b0;
      Data_out  <= '0;
      Src_out   <= SRC_A;
      CP        <= 1'b0;
    end else begin
      CP <= 1'b0;

      case (in_state)
        I_IDLE: begin
          if (grant_en && (gnt != 2'b00)) begin
            Data_out <= gnt[1] ? Data_in_b : Data_in_a;
            Src_out  <= gnt_src(gnt);
            full     <= 1'b1;
            CP       <= 1'b1;
            if (gnt[1]) begin
              Ack_out_b <= 1'b1;
              in_state  <= I_ACK_B;
            end else begin
              Ack_out_a <= 1'b1;
              in_state  <= I_ACK_A;
            end
          end
        end
        I_ACK_A: begin
          if (!Send_in_a) begin
            Ack_out_a <= 1'b0;
            in_state  <= I_IDLE;
          end
        end
        I_ACK_B: begin
          if (!Send_in_b) begin
            Ack_out_b <= 1'b0;
            in_state  <= I_IDLE;
          end
        end
        default: begin
          Ack_out_a <= 1'b0;
          Ack_out_b <= 1'b0;
          in_state  <= I_IDLE;
        end
      endcase

      case (out_state)
        O_IDLE: begin
          if (full) begin
            Send_out  <= 1'b1;
            out_state <= O_SEND;
          end
        end
        O_SEND: begin
          if (Ack_in) begin
            Send_out  <= 1'b0;
            full      <= 1'b0;
            out_state <= O_REL;
          end
        end
        O_REL: begin
          if (!Ack_in) begin
            out_state <= O_IDLE;
          end
        end
        default: begin
          Send_out  <= 1'b0;
          out_state <= O_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cm_merge.sv
// Scoreboard bench for cm_merge: upstream/downstream responders on the falling
// edge, per-source expected queues checked whenever Send_out rises.
module tb_cm_merge;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         MR = 1'b1;
  logic         Send_in_a = 1'b0;
  logic [W-1:0] Data_in_a = '0;
  logic         Ack_out_a;
  logic         Send_in_b = 1'b0;
  logic [W-1:0] Data_in_b = '0;
  logic         Ack_out_b;
  logic         Send_out;
  logic [W-1:0] Data_out;
  logic         Src_out;
  logic         Ack_in = 1'b0;
  logic         CP;

  cm_merge #(.W(W)) dut (
    .CLK       (CLK),
    .MR        (MR),
    .Send_in_a (Send_in_a),
    .Data_in_a (Data_in_a),
    .Ack_out_a (Ack_out_a),
    .Send_in_b (Send_in_b),
    .Data_in_b (Data_in_b),
    .Ack_out_b (Ack_out_b),
    .Send_out  (Send_out),
    .Data_out  (Data_out),
    .Src_out   (Src_out),
    .Ack_in    (Ack_in),
    .CP        (CP)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  logic [W-1:0] pend_a[$];
  logic [W-1:0] pend_b[$];
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic         src_order[$];
  int           rise_times[$];

  int hold_a = 0, hold_b = 0, cnt_a = 0, cnt_b = 0;
  int ds_dly = 0, ds_cnt = 0;
  bit ds_block = 1'b0, ds_rand = 1'b0, tp_rec = 1'b0;
  int cp_cnt = 0, rise_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq_a(input logic [W-1:0] d);
    pend_a.push_back(d);
    exp_a.push_back(d);
  endtask

  task automatic enq_b(input logic [W-1:0] d);
    pend_b.push_back(d);
    exp_b.push_back(d);
  endtask

  function automatic bit drained();
    return pend_a.size() == 0 && pend_b.size() == 0 && exp_a.size() == 0 &&
           exp_b.size() == 0 && src_order.size() == 0 && !Send_in_a && !Send_in_b &&
           !Send_out && !Ack_out_a && !Ack_out_b;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !drained()) begin
      tick();
      n++;
    end
    check(name, 32'(n < budget), 32'(1));
  endtask

  // Upstream and downstream responders: react to outputs seen at the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (MR) begin
        Send_in_a = 1'b0;
        Send_in_b = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        Ack_in = 1'b0;
        ds_cnt = 0;
      end else begin
        if (Send_in_a && Ack_out_a) begin
          cnt_a++;
          if (cnt_a > hold_a) begin
            Send_in_a = 1'b0;
            Data_in_a = 16'($urandom);
            cnt_a = 0;
          end
        end else if (!Send_in_a && !Ack_out_a && pend_a.size() > 0) begin
          Send_in_a = 1'b1;
          Data_in_a = pend_a.pop_front();
        end
        if (Send_in_b && Ack_out_b) begin
          cnt_b++;
          if (cnt_b > hold_b) begin
            Send_in_b = 1'b0;
            Data_in_b = 16'($urandom);
            cnt_b = 0;
          end
        end else if (!Send_in_b && !Ack_out_b && pend_b.size() > 0) begin
          Send_in_b = 1'b1;
          Data_in_b = pend_b.pop_front();
        end
        if (Send_out && !Ack_in && !ds_block) begin
          if (ds_cnt >= ds_dly) begin
            Ack_in = 1'b1;
            ds_cnt = 0;
            if (ds_rand) ds_dly = int'($urandom_range(0, 3));
          end else begin
            ds_cnt++;
          end
        end else if (!Send_out && Ack_in) begin
          Ack_in = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every Send_out rise.
  initial begin
    logic         prev_send = 1'b0;
    logic         prev_cp = 1'b0;
    logic [W-1:0] held = '0;
    logic         held_src = 1'b0;
    forever begin
      @(negedge CLK);
      if (MR) begin
        prev_send = 1'b0;
        prev_cp = 1'b0;
      end else begin
        if (CP) begin
          cp_cnt++;
          check("cp_single_cycle", 32'(prev_cp), 32'(0));
        end
        if (Send_out && !prev_send) begin
          rise_cnt++;
          if (tp_rec) rise_times.push_back(cyc);
          held = Data_out;
          held_src = Src_out;
          if (Src_out == 1'b0) begin
            check("pkt_expected_a", 32'(exp_a.size() > 0), 32'(1));
            if (exp_a.size() > 0) check("data_a", 32'(Data_out), 32'(exp_a.pop_front()));
          end else begin
            check("pkt_expected_b", 32'(exp_b.size() > 0), 32'(1));
            if (exp_b.size() > 0) check("data_b", 32'(Data_out), 32'(exp_b.pop_front()));
          end
          if (src_order.size() > 0) check("rr_order", 32'(Src_out), 32'(src_order.pop_front()));
        end else if (Send_out) begin
          check("data_stable", 32'({Src_out, Data_out}), 32'({held_src, held}));
        end
        prev_send = Send_out;
        prev_cp = CP;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         rr_model;
    logic [W-1:0] d;
    int           n, cp0, r0;

    // Reset values
    MR = 1'b1;
    tick();
    tick();
    check("rst_ack_a", 32'(Ack_out_a), 32'(0));
    check("rst_ack_b", 32'(Ack_out_b), 32'(0));
    check("rst_send", 32'(Send_out), 32'(0));
    check("rst_data", 32'(Data_out), 32'(0));
    check("rst_src", 32'(Src_out), 32'(0));
    check("rst_cp", 32'(CP), 32'(0));
    MR = 1'b0;

    // Single a packet with exact latency
    ds_dly = 1;
    enq_a(16'h1234);
    tick();
    check("t1_ack_a_k", 32'(Ack_out_a), 32'(1));
    check("t1_cp_k", 32'(CP), 32'(1));
    check("t1_data_k", 32'(Data_out), 32'(16'h1234));
    check("t1_src_k", 32'(Src_out), 32'(0));
    check("t1_send_k", 32'(Send_out), 32'(0));
    tick();
    check("t1_send_k1", 32'(Send_out), 32'(1));
    check("t1_cp_k1", 32'(CP), 32'(0));
    check("t1_ack_a_fall", 32'(Ack_out_a), 32'(0));
    wait_drain("t1_drain", 50);

    // Contention: winners of simultaneous requests alternate, starting with a
    ds_dly = 0;
    rr_model = 1'b0;
    for (int r = 0; r < 4; r++) begin
      src_order.push_back(rr_model);
      src_order.push_back(~rr_model);
      enq_a(16'hAAAA);
      enq_b(16'hBBBB);
      wait_drain("t2_drain", 60);
      rr_model = ~rr_model;
    end

    // Back-pressure with b waiting on a full buffer
    ds_block = 1'b1;
    enq_a(16'h5A5A);
    n = 0;
    while (!Send_out && n < 20) begin
      tick();
      n++;
    end
    check("t3_send_rise", 32'(Send_out), 32'(1));
    enq_b(16'hC3C3);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_ack_b_blocked", 32'(Ack_out_b), 32'(0));
      check("t3_send_held", 32'(Send_out), 32'(1));
      check("t3_data_held", 32'(Data_out), 32'(16'h5A5A));
    end
    ds_block = 1'b0;
    tick();
    check("t3_release_send", 32'(Send_out), 32'(0));
    check("t3_no_early_capture", 32'(Ack_out_b), 32'(0));
    tick();
    check("t3_capture_ack_b", 32'(Ack_out_b), 32'(1));
    check("t3_capture_cp", 32'(CP), 32'(1));
    check("t3_capture_data", 32'(Data_out), 32'(16'hC3C3));
    check("t3_capture_src", 32'(Src_out), 32'(1));
    wait_drain("t3_drain", 60);

    // Slow upstream release
    hold_a = 10;
    cp0 = cp_cnt;
    enq_a(16'h0F0F);
    n = 0;
    while (!Ack_out_a && n < 20) begin
      tick();
      n++;
    end
    check("t4_ack_rise", 32'(Ack_out_a), 32'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_ack_held", 32'(Ack_out_a), 32'(1));
    end
    tick();
    check("t4_ack_fall", 32'(Ack_out_a), 32'(0));
    wait_drain("t4_drain", 60);
    check("t4_single_capture", 32'(cp_cnt - cp0), 32'(1));
    hold_a = 0;

    // Reset in O_SEND with Ack_out_a still high
    hold_a = 5;
    ds_block = 1'b1;
    enq_a(16'h7777);
    n = 0;
    while (!Send_out && n < 20) begin
      tick();
      n++;
    end
    check("t5_in_send", 32'(Send_out), 32'(1));
    check("t5_ack_a_high", 32'(Ack_out_a), 32'(1));
    MR = 1'b1;
    pend_a.delete();
    pend_b.delete();
    exp_a.delete();
    exp_b.delete();
    tick();
    check("t5_mr_ack_a", 32'(Ack_out_a), 32'(0));
    check("t5_mr_ack_b", 32'(Ack_out_b), 32'(0));
    check("t5_mr_send", 32'(Send_out), 32'(0));
    check("t5_mr_data", 32'(Data_out), 32'(0));
    check("t5_mr_src", 32'(Src_out), 32'(0));
    check("t5_mr_cp", 32'(CP), 32'(0));
    tick();
    MR = 1'b0;
    hold_a = 0;
    ds_block = 1'b0;
    d = 16'($urandom);
    enq_b(d);
    n = 0;
    while (!Ack_out_b && n < 20) begin
      tick();
      n++;
    end
    check("t5_post_src", 32'(Src_out), 32'(1));
    check("t5_post_data", 32'(Data_out), 32'(d));
    wait_drain("t5_drain", 60);

    // Throughput with immediate responders
    ds_dly = 0;
    tp_rec = 1'b1;
    rise_times.delete();
    cp0 = cp_cnt;
    r0 = rise_cnt;
    for (int i = 0; i < 12; i++) enq_a(16'($urandom));
    wait_drain("t6_drain", 200);
    tp_rec = 1'b0;
    check("t6_rise_count", 32'(rise_cnt - r0), 32'(12));
    check("t6_cp_eq_rise", 32'(cp_cnt - cp0), 32'(rise_cnt - r0));
    for (int i = 1; i < rise_times.size(); i++) begin
      check("t6_interval_le4", 32'((rise_times[i] - rise_times[i-1]) <= 4), 32'(1));
    end

    // Random traffic on both inputs with random downstream delay
    ds_rand = 1'b1;
    cp0 = cp_cnt;
    r0 = rise_cnt;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (pend_a.size() < 2 && $urandom_range(0, 2) == 0) begin
        enq_a(16'($urandom));
        n++;
      end
      if (pend_b.size() < 2 && $urandom_range(0, 2) == 0) begin
        enq_b(16'($urandom));
        n++;
      end
    end
    wait_drain("t7_drain", 3000);
    ds_rand = 1'b0;
    check("t7_rise_count", 32'(rise_cnt - r0), 32'(n));
    check("t7_cp_eq_rise", 32'(cp_cnt - cp0), 32'(rise_cnt - r0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
